rotary_operand_ctrl: RTL and testbench

Front-end controller for the 7-bit adder/subtractor: it turns rotary-encoder quadrature pulses and a push-button into operand editing and calculation sequencing. It sits between the board I/O (ROT_A, ROT_B, button, switch) and the adder/subtractor datapath. It drives the operands, mode and start strobe, then captures the result and overflow onto the LEDs.

---
 rtl/rotary_operand_ctrl.sv | 163 ++++++++++++++++
 tb/tb_rotary_operand_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/rotary_operand_ctrl.sv
// rotary_operand_ctrl: turns rotary encoder detents and a push-button into
// operand editing for the 7-bit adder/subtractor. It issues a start strobe,
// then captures the result and overflow onto the LEDs.
module rotary_operand_ctrl #(
  parameter int RESULT_WAIT = 2,
  parameter int STEP        = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ROT_A,
  input  logic       ROT_B,
  input  logic       BTN_SEL,
  input  logic       SW_SUB,
  input  logic [6:0] sum_in,
  input  logic       ovf_in,
  output logic [6:0] op_a,
  output logic [6:0] op_b,
  output logic       op_sub,
  output logic       op_start,
  output logic [7:0] led,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    EDIT_A = 2'b00,
    EDIT_B = 2'b01,
    CALC   = 2'b10,
    SHOW   = 2'b11
  } state_t;

  localparam logic [6:0] STEP_V   = 7'(STEP);
  localparam logic [3:0] CNT_LAST = 4'(RESULT_WAIT - 1);

  state_t     state;
  logic [3:0] wait_cnt;

  logic rot_a_s1, rot_a_s2, rot_b_s1, rot_b_s2;
  logic btn_s1, btn_s2, btn_d;
  logic q1, q2, q1_d;

  logic       step;
  logic       step_dec;
  logic       press;
  logic [6:0] a_next;
  logic [6:0] b_next;

  // Encoder lines idle high, so their synchronizers reset to 1 and a resting
  // encoder produces no edge when reset is released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rot_a_s1 <= 1'b1;
      rot_a_s2 <= 1'b1;
      rot_b_s1 <= 1'b1;
      rot_b_s2 <= 1'b1;
    end else begin
      rot_a_s1 <= ROT_A;
      rot_a_s2 <= rot_a_s1;
      rot_b_s1 <= ROT_B;
      rot_b_s2 <= rot_b_s1;
    end
  end

  // Button synchronizer plus a delayed copy for single-cycle press detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      btn_d  <= 1'b0;
    end else begin
      btn_s1 <= BTN_SEL;
      btn_s2 <= btn_s1;
      btn_d  <= btn_s2;
    end
  end

  // Quadrature decode: q1 marks a detent when it rises, and q2 remembers
  // which line led into the detent to give the direction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q1   <= 1'b1;
      q2   <= 1'b1;
      q1_d <= 1'b1;
    end else begin
      if (rot_a_s2 && rot_b_s2)
        q1 <= 1'b1;
      else if (!rot_a_s2 && !rot_b_s2)
        q1 <= 1'b0;
      if (rot_a_s2 && !rot_b_s2)
        q2 <= 1'b1;
      else if (!rot_a_s2 && rot_b_s2)
        q2 <= 1'b0;
      q1_d <= q1;
    end
  end

  // Events and the candidate operand values after a detent (modulo 128).
  always_comb begin
    step     = q1 & ~q1_d;
    step_dec = q2;
    press    = btn_s2 & ~btn_d;
    a_next   = op_a;
    b_next   = op_b;
    if (step && state == EDIT_A)
      a_next = step_dec ? (op_a - STEP_V) : (op_a + STEP_V);
    if (step && state == EDIT_B)
      b_next = step_dec ? (op_b - STEP_V) : (op_b + STEP_V);
  end

  // Editing / calculation sequencer with all outputs registered. The LED
  // value always follows the state being entered so it changes on the same
  // edge as the operand or state it reflects.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= EDIT_A;
      op_a     <= 7'd0;
      op_b     <= 7'd0;
      op_sub   <= 1'b0;
      op_start <= 1'b0;
      led      <= 8'd0;
      wait_cnt <= 4'd0;
    end else begin
      op_start <= 1'b0;
      case (state)
        EDIT_A: begin
          op_a <= a_next;
          if (press) begin
            state <= EDIT_B;
            led   <= {1'b0, op_b};
          end else begin
            led   <= {1'b0, a_next};
          end
        end
        EDIT_B: begin
          op_b <= b_next;
          led  <= {1'b0, b_next};
          if (press) begin
            state    <= CALC;
            op_sub   <= SW_SUB;
            op_start <= 1'b1;
            wait_cnt <= 4'd0;
          end
        end
        CALC: begin
          wait_cnt <= wait_cnt + 4'd1;
          if (wait_cnt == CNT_LAST) begin
            led   <= {ovf_in, sum_in};
            state <= SHOW;
          end
        end
        SHOW: begin
          if (press) begin
            state <= EDIT_A;
            led   <= {1'b0, op_a};
          end
        end
        default: state <= EDIT_A;
      endcase
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_rotary_operand_ctrl.sv
// Directed bench for rotary_operand_ctrl with default parameters
// (RESULT_WAIT = 2, STEP = 1).
module tb_rotary_operand_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       rot_a, rot_b, btn, sw_sub;
  logic [6:0] sum_in;
  logic       ovf_in;
  logic [6:0] op_a, op_b;
  logic       op_sub, op_start;
  logic [7:0] led;
  logic [1:0] state_o;

  int compared   = 0;
  int mismatched = 0;

  rotary_operand_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .ROT_A    (rot_a),
    .ROT_B    (rot_b),
    .BTN_SEL  (btn),
    .SW_SUB   (sw_sub),
    .sum_in   (sum_in),
    .ovf_in   (ovf_in),
    .op_a     (op_a),
    .op_b     (op_b),
    .op_sub   (op_sub),
    .op_start (op_start),
    .led      (led),
    .state_o  (state_o)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold one quadrature phase long enough to satisfy the minimum spacing.
  task automatic apply_phase(input logic a, input logic b);
    rot_a = a;
    rot_b = b;
    wait_cycles(6);
  endtask

  // B leads A (10,00,01,11): q2 is cleared last, so the detent increments.
  task automatic detent_inc();
    apply_phase(1'b1, 1'b0);
    apply_phase(1'b0, 1'b0);
    apply_phase(1'b0, 1'b1);
    apply_phase(1'b1, 1'b1);
  endtask

  // A leads B (01,00,10,11): q2 is set last, so the detent decrements.
  task automatic detent_dec();
    apply_phase(1'b0, 1'b1);
    apply_phase(1'b0, 1'b0);
    apply_phase(1'b1, 1'b0);
    apply_phase(1'b1, 1'b1);
  endtask

  task automatic press_release();
    btn = 1'b1;
    wait_cycles(6);
    btn = 1'b0;
    wait_cycles(6);
  endtask

  initial begin
    reset  = 1'b1;
    rot_a  = 1'b1;
    rot_b  = 1'b1;
    btn    = 1'b0;
    sw_sub = 1'b0;
    sum_in = 7'd0;
    ovf_in = 1'b0;
    wait_cycles(3);
    check_output("reset_op_a", {1'b0, op_a}, 8'h00);
    check_output("reset_state", {6'd0, state_o}, 8'h00);
    check_output("reset_led", led, 8'h00);
    reset = 1'b0;

    // Encoder resting high through reset release: no spurious step.
    wait_cycles(10);
    check_output("idle_op_a", {1'b0, op_a}, 8'h00);
    check_output("idle_op_b", {1'b0, op_b}, 8'h00);
    check_output("idle_state", {6'd0, state_o}, 8'h00);

    // Three increments, then four decrements wrapping through zero.
    repeat (3) detent_inc();
    check_output("inc3_op_a", {1'b0, op_a}, 8'h03);
    check_output("inc3_led", led, 8'h03);
    repeat (4) detent_dec();
    check_output("dec4_op_a", {1'b0, op_a}, 8'h7F);
    check_output("dec4_led", led, 8'h7F);

    // Move to EDIT_B and set op_b to 5.
    press_release();
    check_output("edit_b_state", {6'd0, state_o}, 8'h01);
    check_output("edit_b_led0", led, 8'h00);
    repeat (5) detent_inc();
    check_output("edit_b_op_b", {1'b0, op_b}, 8'h05);
    check_output("edit_b_led5", led, 8'h05);
    check_output("edit_b_op_a", {1'b0, op_a}, 8'h7F);

    // Press in subtract mode; CALC is entered at the third edge.
    sw_sub = 1'b1;
    sum_in = 7'h7E;
    ovf_in = 1'b0;
    btn    = 1'b1;
    wait_cycles(2);
    check_output("pre_calc_state", {6'd0, state_o}, 8'h01);
    check_output("pre_calc_start", {7'd0, op_start}, 8'h00);
    wait_cycles(1);
    check_output("calc_state", {6'd0, state_o}, 8'h02);
    check_output("calc_start", {7'd0, op_start}, 8'h01);
    check_output("calc_op_sub", {7'd0, op_sub}, 8'h01);
    wait_cycles(1);
    check_output("calc_start_off", {7'd0, op_start}, 8'h00);
    check_output("calc_no_capture", led, 8'h05);
    check_output("calc_state2", {6'd0, state_o}, 8'h02);
    wait_cycles(1);
    check_output("show_state", {6'd0, state_o}, 8'h03);
    check_output("show_led", led, 8'h7E);
    btn    = 1'b0;
    sw_sub = 1'b0;
    sum_in = 7'h11;
    wait_cycles(6);

    // Steps in SHOW are ignored and the captured value is held.
    detent_inc();
    detent_dec();
    detent_inc();
    check_output("show_op_a", {1'b0, op_a}, 8'h7F);
    check_output("show_op_b", {1'b0, op_b}, 8'h05);
    check_output("show_led_hold", led, 8'h7E);
    check_output("show_start", {7'd0, op_start}, 8'h00);

    // Press in SHOW returns to EDIT_A with operands retained.
    press_release();
    check_output("back_state", {6'd0, state_o}, 8'h00);
    check_output("back_op_a", {1'b0, op_a}, 8'h7F);
    check_output("back_op_sub", {7'd0, op_sub}, 8'h01);
    check_output("back_led", led, 8'h7F);

    // Bring op_a to 10 (127 + 11 wraps to 10).
    repeat (11) detent_inc();
    check_output("ten_op_a", {1'b0, op_a}, 8'h0A);

    // Detent and press landing on the same edge.
    apply_phase(1'b1, 1'b0);
    apply_phase(1'b0, 1'b0);
    apply_phase(1'b0, 1'b1);
    rot_a = 1'b1;
    rot_b = 1'b1;
    wait_cycles(1);
    btn = 1'b1;
    wait_cycles(2);
    check_output("simul_pre_op_a", {1'b0, op_a}, 8'h0A);
    check_output("simul_pre_state", {6'd0, state_o}, 8'h00);
    wait_cycles(1);
    check_output("simul_op_a", {1'b0, op_a}, 8'h0B);
    check_output("simul_state", {6'd0, state_o}, 8'h01);
    check_output("simul_led", led, 8'h05);
    btn = 1'b0;
    wait_cycles(6);

    // Reset during the CALC cycle that follows op_start.
    sum_in = 7'h15;
    ovf_in = 1'b1;
    btn    = 1'b1;
    wait_cycles(3);
    check_output("abort_calc_state", {6'd0, state_o}, 8'h02);
    check_output("abort_calc_start", {7'd0, op_start}, 8'h01);
    wait_cycles(1);
    reset = 1'b1;
    #1;
    check_output("abort_state", {6'd0, state_o}, 8'h00);
    check_output("abort_led", led, 8'h00);
    check_output("abort_op_a", {1'b0, op_a}, 8'h00);
    check_output("abort_op_b", {1'b0, op_b}, 8'h00);
    check_output("abort_op_sub", {7'd0, op_sub}, 8'h00);
    check_output("abort_start", {7'd0, op_start}, 8'h00);
    btn = 1'b0;
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(5);
    check_output("after_abort_state", {6'd0, state_o}, 8'h00);
    check_output("after_abort_led", led, 8'h00);

    $display("[TB] directed sequence complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
